ram_slot_arbiter: RTL and testbench

RAM_SLOT_ARBITER -- requirements
Module: ram_slot_arbiter

---
 rtl/ram_slot_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_slot_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_slot_arbiter.sv
// Memory slot arbiter: alternates A-slots (refresh/video) and B-slots (DMA/blitter/CPU),
// with a refresh tick generator, refresh row counter and CPU starvation override.
module ram_slot_arbiter #(
  parameter int unsigned REFRESH_DIV  = 64,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned RADDR_W      = 9
) (
  input  logic               clk32,
  input  logic               por,
  input  logic               slot_en,
  input  logic               video_req,
  input  logic               dma_req,
  input  logic               blit_req,
  input  logic               cpu_req,
  output logic [4:0]         gnt,
  output logic               slot_phase,
  output logic [RADDR_W-1:0] refresh_addr,
  output logic               refresh_overrun,
  output logic               cpu_promoted
);

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } phase_t;

  localparam logic [7:0] CNT_LAST   = 8'(REFRESH_DIV - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  phase_t             phase_q, phase_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [RADDR_W-1:0] row_q, row_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic [3:0]         starve_q, starve_d;
  logic               prom_q, prom_d;
  logic [4:0]         gnt_q, gnt_d;
  logic               ovr_q, ovr_d;
  logic               wrap;
  logic               ref_gnt;

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      phase_q  <= SLOT_B;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      row_q    <= '0;
      addr_q   <= '0;
      starve_q <= '0;
      prom_q   <= 1'b0;
      gnt_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      starve_q <= starve_d;
      prom_q   <= prom_d;
      gnt_q    <= gnt_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    row_d    = row_q;
    addr_d   = addr_q;
    starve_d = starve_q;
    prom_d   = prom_q;
    gnt_d    = gnt_q;
    ovr_d    = 1'b0;
    wrap     = 1'b0;
    ref_gnt  = 1'b0;

    if (slot_en) begin
      phase_d = (phase_q == SLOT_A) ? SLOT_B : SLOT_A;
      wrap    = (cnt_q == CNT_LAST);
      cnt_d   = wrap ? 8'd0 : cnt_q + 8'd1;
      gnt_d   = '0;

      if (phase_d == SLOT_A) begin
        if (pend_q) begin
          ref_gnt = 1'b1;
          gnt_d   = 5'b00001;
          // Output carries the row being refreshed; the internal counter moves on.
          addr_d  = row_q;
          row_d   = row_q + 1'b1;
        end else if (video_req) begin
          gnt_d = 5'b00010;
        end
      end else begin
        if (prom_q && cpu_req) gnt_d = 5'b10000;
        else if (dma_req)      gnt_d = 5'b00100;
        else if (blit_req)     gnt_d = 5'b01000;
        else if (cpu_req)      gnt_d = 5'b10000;

        if (!cpu_req || gnt_d[4]) begin
          starve_d = '0;
          prom_d   = 1'b0;
        end else begin
          starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
          prom_d   = prom_q || (starve_d >= STARVE_MAX);
        end
      end

      // A tick coinciding with a grant re-arms pending without an overrun.
      pend_d = wrap ? 1'b1 : (ref_gnt ? 1'b0 : pend_q);
      ovr_d  = wrap && pend_q && !ref_gnt;
    end
  end

  assign gnt             = gnt_q;
  assign slot_phase      = phase_q;
  assign refresh_addr    = addr_q;
  assign refresh_overrun = ovr_q;
  assign cpu_promoted    = prom_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Scoreboard bench for ram_slot_arbiter: a slot-level reference model queues expectations,
// a monitor compares after each slot decision and checks outputs hold between slots.
module tb_ram_slot_arbiter;

  localparam int DIV   = 5;
  localparam int LIMIT = 3;
  localparam int AW    = 3;

  logic          clk32 = 1'b0;
  logic          por;
  logic          slot_en;
  logic          video_req, dma_req, blit_req, cpu_req;
  logic [4:0]    gnt;
  logic          slot_phase;
  logic [AW-1:0] refresh_addr;
  logic          refresh_overrun;
  logic          cpu_promoted;

  ram_slot_arbiter #(
    .REFRESH_DIV (DIV),
    .STARVE_LIMIT(LIMIT),
    .RADDR_W     (AW)
  ) dut (
    .clk32          (clk32),
    .por            (por),
    .slot_en        (slot_en),
    .video_req      (video_req),
    .dma_req        (dma_req),
    .blit_req       (blit_req),
    .cpu_req        (cpu_req),
    .gnt            (gnt),
    .slot_phase     (slot_phase),
    .refresh_addr   (refresh_addr),
    .refresh_overrun(refresh_overrun),
    .cpu_promoted   (cpu_promoted)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    int g;
    int ph;
    int addr;
    int ovr;
    int prom;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, in slot-level terms
  int m_n, m_pend, m_rows, m_addr, m_den, m_prom, m_ovr_seen;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pend = 0; m_rows = 0; m_addr = 0; m_den = 0; m_prom = 0;
  endtask

  task automatic model_slot(input int v, input int d, input int b, input int c);
    exp_t e;
    int   wrap, refg, g;
    m_n++;
    wrap = (m_n % DIV == 0);
    refg = 0;
    g    = 0;
    if (m_n % 2 == 1) begin
      if (m_pend != 0) begin
        g = 1; refg = 1;
        m_addr = m_rows;
        m_rows = (m_rows + 1) % (1 << AW);
      end else if (v != 0) g = 2;
    end else begin
      if (m_prom != 0 && c != 0) g = 16;
      else if (d != 0)           g = 4;
      else if (b != 0)           g = 8;
      else if (c != 0)           g = 16;
      if (c == 0 || g == 16) begin
        m_den = 0; m_prom = 0;
      end else begin
        m_den = (m_den < 15) ? m_den + 1 : 15;
        if (m_den >= LIMIT) m_prom = 1;
      end
    end
    e.g    = g;
    e.ph   = (m_n % 2 == 1) ? 0 : 1;
    e.addr = m_addr;
    e.ovr  = (wrap != 0 && m_pend != 0 && refg == 0) ? 1 : 0;
    e.prom = m_prom;
    if (wrap != 0) m_pend = 1;
    else if (refg != 0) m_pend = 0;
    exp_q.push_back(e);
  endtask

  // Issue one slot at posedge+2, then idle for gap cycles (gap 0 allows back-to-back slots)
  task automatic slot(input int v, input int d, input int b, input int c, input int gap);
    video_req = v[0]; dma_req = d[0]; blit_req = b[0]; cpu_req = c[0];
    slot_en = 1'b1;
    model_slot(v, d, b, c);
    @(posedge clk32); #2;
    slot_en = 1'b0;
    {video_req, dma_req, blit_req, cpu_req} = 4'($urandom);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk32); #2;
    end
  endtask

  // Monitor: compares after each sampled slot_en, checks hold otherwise
  logic sampled = 1'b0;
  exp_t last;
  always @(posedge clk32) sampled <= slot_en && !por;

  always @(negedge clk32) begin
    if (por) begin
      last.g = 0; last.ph = 1; last.addr = 0; last.ovr = 0; last.prom = 0;
    end else if (sampled) begin
      if (exp_q.size() == 0) begin
        check("unexpected_slot", 1, 0);
      end else begin
        last = exp_q.pop_front();
        check("gnt", int'(gnt), last.g);
        check("slot_phase", int'(slot_phase), last.ph);
        check("refresh_addr", int'(refresh_addr), last.addr);
        check("refresh_overrun", int'(refresh_overrun), last.ovr);
        check("cpu_promoted", int'(cpu_promoted), last.prom);
      end
    end else begin
      check("hold_gnt", int'(gnt), last.g);
      check("hold_phase", int'(slot_phase), last.ph);
      check("hold_addr", int'(refresh_addr), last.addr);
      check("hold_overrun", int'(refresh_overrun), 0);
      check("hold_prom", int'(cpu_promoted), last.prom);
    end
  end

  initial begin
    por = 1'b1; slot_en = 1'b0;
    {video_req, dma_req, blit_req, cpu_req} = 4'b0;
    model_reset();
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_phase", int'(slot_phase), 1);
    check("reset_addr", int'(refresh_addr), 0);
    check("reset_ovr", int'(refresh_overrun), 0);
    check("reset_prom", int'(cpu_promoted), 0);
    repeat (3) @(posedge clk32);
    #2 por = 1'b0;
    repeat (3) begin @(posedge clk32); #2; end

    // Video + CPU alternating with wide slot spacing
    for (int i = 0; i < 8; i++) slot(1, 0, 0, 1, 15);

    // All B requesters held: starvation and promotion
    for (int i = 0; i < 24; i++) slot(1, 1, 1, 1, 1);

    // Randomized traffic, including back-to-back slots
    for (int i = 0; i < 400; i++)
      slot(($urandom_range(3) != 0) ? 1 : 0, ($urandom_range(2) == 0) ? 1 : 0,
           int'($urandom_range(1)), ($urandom_range(3) != 0) ? 1 : 0,
           int'($urandom_range(3)));

    // Reset during a granted B-slot
    if (m_n % 2 == 0) slot(1, 1, 0, 0, 2);
    slot(0, 1, 0, 0, 2);
    #1 por = 1'b1;
    #1;
    check("por_async_gnt", int'(gnt), 0);
    check("por_async_phase", int'(slot_phase), 1);
    check("por_async_prom", int'(cpu_promoted), 0);
    check("por_async_addr", int'(refresh_addr), 0);
    model_reset();
    @(posedge clk32); #2 por = 1'b0;
    repeat (2) begin @(posedge clk32); #2; end
    for (int i = 0; i < 60; i++)
      slot(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
           int'($urandom_range(1)), int'($urandom_range(2)));

    repeat (4) @(posedge clk32);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
